// File: rtl/oka_pkg.sv
// Shared types and widths for the sequential Karatsuba carry-less multiplier.
package oka_pkg;
  localparam int W  = 64;
  localparam int HW = W / 2;
  localparam int PW = 2 * HW - 1;
  localparam int YW = 2 * W - 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL0 = 3'd1,
    MUL1 = 3'd2,
    MUL2 = 3'd3,
    OUT  = 3'd4
  } oka_state_t;
endpackage

// File: rtl/oka_mul_seq_ctrl_clmul_half.sv
// Combinational half-width carry-less multiplier; the one core shared by all three Karatsuba products.
module clmul_half #(
  parameter int HW = 32
) (
  input  logic [HW-1:0]   a,
  input  logic [HW-1:0]   b,
  output logic [2*HW-2:0] p
);
  localparam int PW = 2 * HW - 1;

  logic [PW-1:0] a_ext;

  assign a_ext = {{(PW-HW){1'b0}}, a};

  always_comb begin
    p = '0;
    for (int i = 0; i < HW; i++) begin
      if (b[i]) p = p ^ (a_ext << i);
    end
  end
endmodule

// File: rtl/oka_mul_seq_ctrl.sv
// Iterative 64x64 carry-less Karatsuba multiplier: one shared core, used in MUL0/MUL1/MUL2.
module oka_mul_seq_ctrl #(
  parameter int W = oka_pkg::W  // must be even and >= 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-2:0] y,
  output logic           busy
);
  import oka_pkg::*;

  localparam int HW = W / 2;
  localparam int PW = 2 * HW - 1;
  localparam int YW = 2 * W - 1;

  oka_state_t state_q, state_d;

  logic [W-1:0]  a_q, b_q;
  logic [PW-1:0] z0_q, z1_q;
  logic [YW-1:0] y_q;
  logic          out_valid_q;
  logic [HW-1:0] core_a, core_b;
  logic [PW-1:0] core_p;

  // y = z0 ^ ((z0^z1^z2) << HW) ^ (z2 << W), all terms zero-extended to YW
  function automatic logic [YW-1:0] recombine(input logic [PW-1:0] z0,
                                              input logic [PW-1:0] z1,
                                              input logic [PW-1:0] z2);
    logic [YW-1:0] e0, em, e2;
    e0 = {{(YW-PW){1'b0}}, z0};
    em = {{(YW-PW){1'b0}}, z0 ^ z1 ^ z2};
    e2 = {{(YW-PW){1'b0}}, z2};
    return e0 ^ (em << HW) ^ (e2 << W);
  endfunction

  clmul_half #(.HW(HW)) u_core (
    .a (core_a),
    .b (core_b),
    .p (core_p)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_d == OUT);
    end
  end

  // flush outranks every handshake
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (in_valid) state_d = MUL0;
        MUL0:    state_d = MUL1;
        MUL1:    state_d = MUL2;
        MUL2:    state_d = OUT;
        OUT:     if (out_ready) state_d = in_valid ? MUL0 : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = (state_q != IDLE);
    core_a   = '0;
    core_b   = '0;
    case (state_q)
      IDLE: in_ready = !flush;
      OUT:  in_ready = !flush && out_ready;
      MUL0: begin
        core_a = a_q[HW-1:0];
        core_b = b_q[HW-1:0];
      end
      MUL1: begin
        core_a = a_q[HW-1:0] ^ a_q[W-1:HW];
        core_b = b_q[HW-1:0] ^ b_q[W-1:HW];
      end
      MUL2: begin
        core_a = a_q[W-1:HW];
        core_b = b_q[W-1:HW];
      end
      default: ;
    endcase
  end

  // operand capture, partial products and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      z0_q <= '0;
      z1_q <= '0;
      y_q  <= '0;
    end else begin
      if (in_valid && in_ready) begin
        a_q <= a;
        b_q <= b;
      end
      if (!flush) begin
        case (state_q)
          MUL0:    z0_q <= core_p;
          MUL1:    z1_q <= core_p;
          MUL2:    y_q  <= recombine(z0_q, z1_q, core_p);
          default: ;
        endcase
      end
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;
endmodule

// File: tb/tb_oka_mul_seq_ctrl.sv
// Scoreboard bench for oka_mul_seq_ctrl: driver pushes expected products, negedge monitor pops on each output handshake.
module tb_oka_mul_seq_ctrl;
  logic         clk = 1'b0;
  logic         rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [63:0]  a, b;
  logic [126:0] y;

  int           total = 0;
  int           bad   = 0;
  longint       cyc   = 0;
  longint       last_hs = -1;
  bit           tp_mode = 1'b0;
  logic [126:0] exp_q[$];
  logic [126:0] cur_exp = '0;

  oka_mul_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [126:0] clmul_ref(input logic [63:0] x, input logic [63:0] z);
    logic [126:0] acc, xe;
    acc = '0;
    xe  = {63'b0, x};
    for (int i = 0; i < 64; i++) if (z[i]) acc = acc ^ (xe << i);
    return acc;
  endfunction

  task automatic check(input string nm, input logic [126:0] act, input logic [126:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // monitor: handshakes seen at negedge complete on the following posedge
  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready_rule", {126'b0, in_ready},
            {126'b0, !flush && (!busy || (out_valid && out_ready))});
      if (in_valid && in_ready) exp_q.push_back(cur_exp);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_output", 127'd1, 127'd0);
        else check("result", y, exp_q.pop_front());
        if (tp_mode && last_hs >= 0) check("interval", 127'(cyc - last_hs), 127'd4);
        last_hs = cyc;
      end
    end
  end

  task automatic send(input logic [63:0] ta, input logic [63:0] tb, input logic [126:0] te);
    int n;
    a = ta; b = tb; cur_exp = te; in_valid = 1'b1; n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 100);
    if (!in_ready) check("accept_timeout", 127'd0, 127'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((busy || out_valid || exp_q.size() != 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) check("drain_timeout", 127'd0, 127'd1);
  endtask

  initial begin
    logic [126:0] held;
    logic [63:0]  ra, rb;
    int           edges;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    #1;
    check("rst_out_valid", {126'b0, out_valid}, 127'd0);
    check("rst_y", y, 127'd0);
    check("rst_busy", {126'b0, busy}, 127'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", {126'b0, in_ready}, 127'd1);

    // (x+1)^2 and the four-edge latency
    send(64'h3, 64'h3, 127'h5);
    edges = 1;
    while (!out_valid && edges < 10) begin
      @(posedge clk); #1;
      edges++;
    end
    check("latency_edges", 127'(edges), 127'd4);
    wait_done();

    send(64'h1_0000_0000, 64'h1_0000_0000, 127'h1 << 64);
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, {63'b0, 64'hFFFF_FFFF_FFFF_FFFF});
    send(64'h5, 64'h7, 127'h1B);
    wait_done();

    // back-to-back random traffic, one result every 4 cycles
    tp_mode = 1'b1; last_hs = -1;
    for (int i = 0; i < 10000; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      send(ra, rb, clmul_ref(ra, rb));
    end
    wait_done();
    tp_mode = 1'b0;

    // backpressure, then both handshakes on one edge
    out_ready = 1'b0;
    ra = 64'hDEAD_BEEF_0123_4567; rb = 64'h8000_0000_0000_0001;
    send(ra, rb, clmul_ref(ra, rb));
    edges = 0;
    while (!out_valid && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    held = y;
    ra = 64'hFFFF_FFFF_FFFF_FFFF;
    a = ra; b = ra; cur_exp = 127'h5555_5555_5555_5555_5555_5555_5555_5555; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_valid", {126'b0, out_valid}, 127'd1);
      check("bp_y_stable", y, held);
      check("bp_in_ready", {126'b0, in_ready}, 127'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_same_edge_accept", {126'b0, busy && !out_valid}, 127'd1);
    wait_done();

    // reset while in MUL1
    send(64'h1234_5678_9ABC_DEF0, 64'h0F0F_0F0F_F0F0_F0F0, 127'd0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("rst_mid_out_valid", {126'b0, out_valid}, 127'd0);
    check("rst_mid_y", y, 127'd0);
    check("rst_mid_busy", {126'b0, busy}, 127'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    send(64'h5, 64'h7, 127'h1B);
    wait_done();

    // flush in MUL2 drops the op; y keeps the last result
    send(64'hAAAA_0000_5555_FFFF, 64'h3, 127'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1; in_valid = 1'b1; a = 64'h9; b = 64'h9;
    #3;
    check("flush_in_ready", {126'b0, in_ready}, 127'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_busy", {126'b0, busy}, 127'd0);
    check("flush_out_valid", {126'b0, out_valid}, 127'd0);
    check("flush_y_held", y, 127'h1B);
    if (exp_q.size() != 0) void'(exp_q.pop_back());
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("flush_no_pulse", {126'b0, out_valid}, 127'd0);
    end

    // flush in IDLE with in_valid: nothing accepted
    flush = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    check("flush_idle_in_ready", {126'b0, in_ready}, 127'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_idle_busy", {126'b0, busy}, 127'd0);

    send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
         127'h5555_5555_5555_5555_5555_5555_5555_5555);
    wait_done();
    check("queue_empty", 127'(exp_q.size()), 127'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
